// File: rtl/nth_select_sorter.sv
// nth_select_sorter: odd-even transposition sort, returns the element of a requested rank.
// Define NTH_SELECT_SIGNED_EN to compare elements as two's-complement values (default unsigned).
module nth_select_sorter #(
    parameter int WIDTH = 32,
    parameter int NUM   = 8,
    localparam int IDX_W = $clog2(NUM)
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] numbers_in [NUM],
    input  logic [IDX_W-1:0] index_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic [WIDTH-1:0] result_out,
    output logic [IDX_W-1:0] src_out,
    output logic             valid_out,
    input  logic             ready_in
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [IDX_W:0]   NUM_EXT   = (IDX_W+1)'(NUM);
    localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(NUM - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] phase_q, phase_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] vals_q [NUM];
    logic [WIDTH-1:0] vals_d [NUM];
    logic [IDX_W-1:0] tags_q [NUM];
    logic [IDX_W-1:0] tags_d [NUM];

    logic             accept;
    logic             last_phase;
    logic [IDX_W-1:0] idx_clamped;

    function automatic logic greater(input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b);
`ifdef NTH_SELECT_SIGNED_EN
        return $signed(a) > $signed(b);
`else
        return a > b;
`endif
    endfunction

    assign accept      = (state_q == IDLE) && valid_in;
    assign last_phase  = (phase_q == LAST_SLOT);
    assign idx_clamped = ({1'b0, index_in} >= NUM_EXT) ? LAST_SLOT : index_in;

    // State and datapath registers
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            phase_q <= '0;
            idx_q   <= '0;
            for (int i = 0; i < NUM; i++) begin
                vals_q[i] <= '0;
                tags_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            idx_q   <= idx_d;
            for (int i = 0; i < NUM; i++) begin
                vals_q[i] <= vals_d[i];
                tags_q[i] <= tags_d[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (valid_in)   state_d = SORT;
            SORT:    if (last_phase) state_d = DONE;
            DONE:    if (ready_in)   state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    // Pairs never overlap within a phase, so all swaps can resolve in parallel
    always_comb begin
        phase_d = phase_q;
        idx_d   = idx_q;
        for (int i = 0; i < NUM; i++) begin
            vals_d[i] = vals_q[i];
            tags_d[i] = tags_q[i];
        end
        if (accept) begin
            phase_d = '0;
            idx_d   = idx_clamped;
            for (int i = 0; i < NUM; i++) begin
                vals_d[i] = numbers_in[i];
                tags_d[i] = IDX_W'(i);
            end
        end else if (state_q == SORT) begin
            phase_d = last_phase ? '0 : phase_q + 1'b1;
            for (int i = 0; i < NUM - 1; i++) begin
                if (((i % 2) == int'(phase_q[0])) &&
                    greater(vals_q[i], vals_q[i+1])) begin
                    vals_d[i]   = vals_q[i+1];
                    vals_d[i+1] = vals_q[i];
                    tags_d[i]   = tags_q[i+1];
                    tags_d[i+1] = tags_q[i];
                end
            end
        end
    end

    always_comb begin
        ready_out  = 1'b0;
        valid_out  = 1'b0;
        result_out = '0;
        src_out    = '0;
        unique case (state_q)
            IDLE: ready_out = 1'b1;
            DONE: begin
                valid_out  = 1'b1;
                result_out = vals_q[idx_q];
                src_out    = tags_q[idx_q];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_nth_select_sorter.sv
// Bench for nth_select_sorter: NUM=4 and NUM=16 instances, rank-counting
// reference model checked every cycle, plus directed literal cases.
module tb_nth_select_sorter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic cmp_en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] n4 [4];
    logic [1:0] i4;
    logic       v4, rdy4, ro4, vo4;
    logic [7:0] res4;
    logic [1:0] src4;

    logic [7:0] n16 [16];
    logic [3:0] i16;
    logic       v16, rdy16, ro16, vo16;
    logic [7:0] res16;
    logic [3:0] src16;

    nth_select_sorter #(.WIDTH(8), .NUM(4)) u_dut4 (
        .clk_in(clk), .rst_in(rst), .numbers_in(n4), .index_in(i4),
        .valid_in(v4), .ready_out(ro4), .result_out(res4), .src_out(src4),
        .valid_out(vo4), .ready_in(rdy4)
    );

    nth_select_sorter #(.WIDTH(8), .NUM(16)) u_dut16 (
        .clk_in(clk), .rst_in(rst), .numbers_in(n16), .index_in(i16),
        .valid_in(v16), .ready_out(ro16), .result_out(res16), .src_out(src16),
        .valid_out(vo16), .ready_in(rdy16)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit lt(input logic [7:0] a, input logic [7:0] b);
`ifdef NTH_SELECT_SIGNED_EN
        return $signed(a) < $signed(b);
`else
        return a < b;
`endif
    endfunction

    // Stable rank: smaller values, plus equal values from earlier positions
    function automatic void sel(input logic [7:0] v [16], input int n, input int idx,
                                output logic [7:0] r, output int s);
        int k = (idx >= n) ? n - 1 : idx;
        r = '0;
        s = 0;
        for (int j = 0; j < n; j++) begin
            int rank = 0;
            for (int m = 0; m < n; m++)
                if (lt(v[m], v[j]) || (v[m] == v[j] && m < j)) rank++;
            if (rank == k) begin
                r = v[j];
                s = j;
            end
        end
    endfunction

    bit         m4_busy, m4_done, m16_busy, m16_done;
    int         m4_cnt, m16_cnt, m4_s, m16_s;
    logic [7:0] m4_r, m16_r;
    logic [7:0] t4 [16];
    logic [7:0] t16 [16];

    always @(posedge clk) begin
        if (rst) begin
            m4_busy = 0; m4_done = 0; m4_cnt = 0;
        end else if (m4_done) begin
            if (rdy4) m4_done = 0;
        end else if (m4_busy) begin
            m4_cnt--;
            if (m4_cnt == 0) begin m4_busy = 0; m4_done = 1; end
        end else if (v4) begin
            for (int i = 0; i < 16; i++) t4[i] = (i < 4) ? n4[i] : 8'h0;
            sel(t4, 4, int'(i4), m4_r, m4_s);
            m4_busy = 1; m4_cnt = 4;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            m16_busy = 0; m16_done = 0; m16_cnt = 0;
        end else if (m16_done) begin
            if (rdy16) m16_done = 0;
        end else if (m16_busy) begin
            m16_cnt--;
            if (m16_cnt == 0) begin m16_busy = 0; m16_done = 1; end
        end else if (v16) begin
            for (int i = 0; i < 16; i++) t16[i] = n16[i];
            sel(t16, 16, int'(i16), m16_r, m16_s);
            m16_busy = 1; m16_cnt = 16;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("ready4",   32'(ro4),   32'(!(m4_busy || m4_done)));
            chk("valid4",   32'(vo4),   32'(m4_done));
            chk("result4",  32'(res4),  m4_done ? 32'(m4_r) : 32'd0);
            chk("src4",     32'(src4),  m4_done ? 32'(m4_s) : 32'd0);
            chk("ready16",  32'(ro16),  32'(!(m16_busy || m16_done)));
            chk("valid16",  32'(vo16),  32'(m16_done));
            chk("result16", 32'(res16), m16_done ? 32'(m16_r) : 32'd0);
            chk("src16",    32'(src16), m16_done ? 32'(m16_s) : 32'd0);
        end
    end

    task automatic run4(input logic [7:0] a0, input logic [7:0] a1,
                        input logic [7:0] a2, input logic [7:0] a3,
                        input logic [1:0] idx, input int hold,
                        output logic [7:0] r, output logic [1:0] s, output int lat);
        int g = 0;
        @(negedge clk);
        while (!ro4 && g < 100) begin @(negedge clk); g++; end
        chk("run4_ready", 32'(ro4), 32'd1);
        n4 = '{a0, a1, a2, a3};
        i4 = idx; v4 = 1'b1; rdy4 = 1'b0;
        @(negedge clk);
        v4 = 1'b0;
        lat = 0;
        while (!vo4 && lat < 100) begin @(negedge clk); lat++; end
        r = res4;
        s = src4;
        repeat (hold) begin
            @(negedge clk);
            chk("hold_valid", 32'(vo4),  32'd1);
            chk("hold_res",   32'(res4), 32'(r));
            chk("hold_src",   32'(src4), 32'(s));
            chk("hold_ready", 32'(ro4),  32'd0);
        end
        rdy4 = 1'b1;
        @(negedge clk);
        rdy4 = 1'b0;
        chk("drop_valid4", 32'(vo4), 32'd0);
        chk("idle_ready4", 32'(ro4), 32'd1);
    endtask

    task automatic run16(input logic [7:0] v [16], input logic [3:0] idx,
                         output logic [7:0] r, output logic [3:0] s, output int lat);
        int g = 0;
        @(negedge clk);
        while (!ro16 && g < 100) begin @(negedge clk); g++; end
        chk("run16_ready", 32'(ro16), 32'd1);
        n16 = v;
        i16 = idx; v16 = 1'b1; rdy16 = 1'b0;
        @(negedge clk);
        v16 = 1'b0;
        lat = 0;
        while (!vo16 && lat < 100) begin @(negedge clk); lat++; end
        r = res16;
        s = src16;
        rdy16 = 1'b1;
        @(negedge clk);
        rdy16 = 1'b0;
        chk("drop_valid16", 32'(vo16), 32'd0);
    endtask

    initial begin
        logic [7:0] r;
        logic [1:0] s;
        logic [7:0] r16;
        logic [3:0] s16;
        logic [7:0] rev [16];
        int lat;

        rst = 1'b1;
        v4 = 0; rdy4 = 0; i4 = 0; v16 = 0; rdy16 = 0; i16 = 0;
        n4 = '{default: 8'h0};
        n16 = '{default: 8'h0};
        repeat (2) @(posedge clk);
        @(negedge clk);
        cmp_en = 1'b1;
        chk("rst_ready4",  32'(ro4),   32'd1);
        chk("rst_valid4",  32'(vo4),   32'd0);
        chk("rst_result4", 32'(res4),  32'd0);
        chk("rst_src4",    32'(src4),  32'd0);
        chk("rst_ready16", 32'(ro16),  32'd1);
        rst = 1'b0;

        run4(8'd9, 8'd3, 8'd7, 8'd1, 2'd2, 0, r, s, lat);
        chk("basic_lat", 32'(lat), 32'd4);
        chk("basic_res", 32'(r),   32'd7);
        chk("basic_src", 32'(s),   32'd2);

        run4(8'd5, 8'd5, 8'd2, 8'd5, 2'd1, 0, r, s, lat);
        chk("tie1_res", 32'(r), 32'd5);
        chk("tie1_src", 32'(s), 32'd0);
        run4(8'd5, 8'd5, 8'd2, 8'd5, 2'd2, 0, r, s, lat);
        chk("tie2_res", 32'(r), 32'd5);
        chk("tie2_src", 32'(s), 32'd1);

        run4(8'h80, 8'h01, 8'h7F, 8'hFF, 2'd0, 0, r, s, lat);
`ifdef NTH_SELECT_SIGNED_EN
        chk("sign_res", 32'(r), 32'h80);
        chk("sign_src", 32'(s), 32'd0);
`else
        chk("sign_res", 32'(r), 32'h01);
        chk("sign_src", 32'(s), 32'd1);
`endif

        run4(8'd9, 8'd3, 8'd7, 8'd1, 2'd3, 5, r, s, lat);
        chk("stall_res", 32'(r), 32'd9);
        chk("stall_src", 32'(s), 32'd0);

        // abort mid-sort
        @(negedge clk);
        n4 = '{8'd9, 8'd3, 8'd7, 8'd1};
        i4 = 2'd0; v4 = 1'b1;
        @(negedge clk);
        v4 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ready", 32'(ro4), 32'd1);
        chk("abort_valid", 32'(vo4), 32'd0);
        repeat (6) begin
            @(negedge clk);
            chk("abort_novalid", 32'(vo4), 32'd0);
        end
        run4(8'd4, 8'd3, 8'd2, 8'd1, 2'd3, 0, r, s, lat);
        chk("fresh_res", 32'(r), 32'd4);
        chk("fresh_src", 32'(s), 32'd0);

        for (int i = 0; i < 16; i++) rev[i] = 8'(15 - i);
        for (int k = 0; k < 16; k++) begin
            run16(rev, 4'(k), r16, s16, lat);
            chk("sweep_res", 32'(r16), 32'(k));
            chk("sweep_src", 32'(s16), 32'(15 - k));
            chk("sweep_lat", 32'(lat), 32'd16);
        end

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 199) == 0);
            v4 = 1'($urandom_range(0, 1));
            v16 = 1'($urandom_range(0, 1));
            rdy4 = ($urandom_range(0, 2) != 0);
            rdy16 = ($urandom_range(0, 2) != 0);
            i4 = 2'($urandom);
            i16 = 4'($urandom);
            for (int i = 0; i < 4; i++)
                n4[i] = c[0] ? 8'($urandom) : 8'($urandom_range(0, 3));
            for (int i = 0; i < 16; i++)
                n16[i] = c[1] ? 8'($urandom) : 8'($urandom_range(0, 5));
        end
        @(negedge clk);
        rst = 1'b0; v4 = 0; v16 = 0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
